geo_window_rd: RTL and testbench
================================

// Module: geo_window_rd
// PURPOSE
//  Read-side responder for the GeoRAM window at IO1 ($DE00-$DEFF).
//  Forms the 22-bit RAM address {Block, Window, A[7:0]} from the bank/page registers.
//  Serves C64 window reads from a one-byte buffer; on a miss, fetches from backing RAM over a req/ack port and stalls the C64.
//  Sits between the register block (Block/Window outputs) and the RAM arbiter.
// PARAMETERS
//  MEM_AW   22  backing-RAM address width; must equal 8+6+8
//  NOFETCH  0   reserved, tie 0 (no effect)
// PORTS
//  PHI2     in   1   C64 PHI2 clock; all state updates on posedge
//  nRESET   in   1   reset, synchronous, active-low
//  WinSEL   in   1   IO1 window select (C64 access to $DE00-$DEFF)
//  nWE      in   1   C64 write strobe, active low
//  A        in   8   C64 A[7:0], offset within the page
//  WRD      in   8   C64 write data, snooped for coherence
//  Block    in   8   16 KB bank select from the register block
//  Window   in   6   256 B page within the bank, from the register block
//  RDD      out  8   read data to the C64 bus
//  RDOE     out  1   drive RDD onto the bus
//  Stall    out  1   read miss; top level holds C64 RDY low
//  MemREQ   out  1   backing-RAM read request
//  MemADDR  out  22  backing-RAM read address
//  MemACK   in   1   data-ready strobe from the RAM arbiter
//  MemRD    in   8   backing-RAM read data
// BEHAVIOUR
//  - Reset (nRESET=0 at posedge): PfValid=0, PfAddr=0, PfData=0, MemREQ=0, MemADDR=0, Stale=0, FSM=IDLE.
//    Reset mid-fetch abandons the request; the next MemACK is ignored.
//  - CurAddr = {Block,Window,A}; Rd = WinSEL&nWE; Wr = WinSEL&~nWE; Hit = PfValid&(PfAddr==CurAddr).
//  - Combinational outputs:
//    RDOE = Rd&Hit; RDD = PfData; Stall = Rd&~Hit.
//  - FSM states: IDLE, FETCH, GAP.
//    - IDLE, Rd&~Hit: MemADDR<=CurAddr, MemREQ<=1, PfValid<=0 -> FETCH.
//    - FETCH: MemREQ and MemADDR are held stable until an edge with MemACK=1.
//      On that edge: MemREQ<=0 -> GAP.
//      If ~Stale: PfData<=MemRD, PfAddr<=MemADDR, PfValid<=1.
//      If Stale: discard the data and clear Stale.
//    - GAP: one mandatory idle cycle with MemREQ=0 -> IDLE.
//      A pending miss or prefetch launches from IDLE on the next edge.
//  - A miss to a different address while in FETCH: the current fetch is completed and then discarded (Stale=1).
//    The miss is re-detected after GAP.
//  - Write snoop:
//    - Wr with CurAddr==PfAddr & PfValid: PfData<=WRD.
//    - Wr with CurAddr==MemADDR in FETCH: Stale<=1.
//  - A Block/Window change needs no explicit flush; the address compare covers it.
//  - Read latency: a hit returns data in the same cycle; a miss takes MemACK latency + 2 PHI2 cycles before the retried read hits.
// CONFIGURATION
//  GEO_RD_PREFETCH_EN defined:
//    - On an edge with Rd&Hit in IDLE, launch a fetch of {Block,Window,A+1}.
//    - A+1 wraps 0xFF->0x00 with no carry into Window.
//    - PfData stays valid for reads until that fetch's ACK.
//    - While such a prefetch is in FETCH, a repeated read of the old PfAddr still hits.
//    - Result: sequential page copies stall only on their first byte.
//  Undefined:
//    - Fetches happen on miss only.
//    - Repeated reads of the last fetched byte hit; sequential reads all miss.
// TESTING
//  1 Reset, Block=0x12 Window=0x05, read A=0x40 -> Stall=1, MemREQ=1 MemADDR=0x048540.
//    ACK data 0x5A -> after GAP, retried read gives RDOE=1 RDD=0x5A Stall=0.
//  2 PREFETCH_EN, hit at A=0xFF -> MemADDR=0x048500 (page wrap, Window unchanged).
//    Without the macro -> no MemREQ.
//  3 Write 0x77 to the buffered address, then read it -> RDD=0x77, no MemREQ.
//  4 Write to MemADDR during FETCH, ACK 0x11 -> data discarded.
//    Read stays Stall=1 and a refetch is issued after GAP.
//  5 nRESET=0 while MemREQ=1 -> MemREQ=0 next edge.
//    A late MemACK does not set PfValid; the first read afterwards misses.
//  6 Window changed from 0x05 to 0x06, read the same A -> Stall=1, MemADDR=0x048640.

Source files
------------

// File: rtl/geo_window_rd.sv
// rtl/geo_window_rd.sv - GeoRAM IO1 window read responder with a one-byte read buffer
// Optional feature GEO_RD_PREFETCH_EN: after each buffered hit, prefetch A+1 (page-wrapping).
module geo_window_rd #(
  parameter int MEM_AW  = 22,
  parameter bit NOFETCH = 1'b0
) (
  input  logic              PHI2,
  input  logic              nRESET,
  input  logic              WinSEL,
  input  logic              nWE,
  input  logic [7:0]        A,
  input  logic [7:0]        WRD,
  input  logic [7:0]        Block,
  input  logic [5:0]        Window,
  output logic [7:0]        RDD,
  output logic              RDOE,
  output logic              Stall,
  output logic              MemREQ,
  output logic [MEM_AW-1:0] MemADDR,
  input  logic              MemACK,
  input  logic [7:0]        MemRD
);

  if (MEM_AW != 22 || NOFETCH != 1'b0) begin : gParamCheck
    $error("geo_window_rd: MEM_AW must be 22 and NOFETCH must be 0");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StGap} geoState;

  geoState           state, nState;
  logic              pfValid, nPfValid;
  logic [MEM_AW-1:0] pfAddr, nPfAddr;
  logic [7:0]        pfData, nPfData;
  logic              nMemReq;
  logic [MEM_AW-1:0] nMemAddr;
  logic              stale, nStale;

  logic [MEM_AW-1:0] curAddr;
  logic              rd, wr, hit, wrFetchAddr;

  assign curAddr     = {Block, Window, A};
  assign rd          = WinSEL & nWE;
  assign wr          = WinSEL & ~nWE;
  assign hit         = pfValid & (pfAddr == curAddr);
  assign wrFetchAddr = wr & (curAddr == MemADDR);

  assign RDOE  = rd & hit;
  assign RDD   = pfData;
  assign Stall = rd & ~hit;

`ifdef GEO_RD_PREFETCH_EN
  logic [MEM_AW-1:0] nextAddr;
  // A+1 is evaluated at 8 bits so 0xFF wraps to 0x00 without touching Window.
  assign nextAddr = {Block, Window, A + 8'd1};
`endif

  always_comb begin
    nState   = state;
    nPfValid = pfValid;
    nPfAddr  = pfAddr;
    nPfData  = pfData;
    nMemReq  = MemREQ;
    nMemAddr = MemADDR;
    nStale   = stale;

    if (wr && pfValid && (curAddr == pfAddr)) begin
      nPfData = WRD;
    end

    case (state)
      StIdle: begin
        if (rd && !hit) begin
          nMemAddr = curAddr;
          nMemReq  = 1'b1;
          nPfValid = 1'b0;
          nState   = StFetch;
        end
`ifdef GEO_RD_PREFETCH_EN
        else if (rd && hit) begin
          // The old buffer keeps serving reads until this fetch lands.
          nMemAddr = nextAddr;
          nMemReq  = 1'b1;
          nState   = StFetch;
        end
`endif
      end

      StFetch: begin
        if (MemACK) begin
          nMemReq = 1'b0;
          nStale  = 1'b0;
          nState  = StGap;
          // A write to the fetched address on the ACK edge also makes the data stale.
          if (!stale && !wrFetchAddr) begin
            nPfData  = MemRD;
            nPfAddr  = MemADDR;
            nPfValid = 1'b1;
          end
        end else if (wrFetchAddr || (rd && !hit && (curAddr != MemADDR))) begin
          nStale = 1'b1;
        end
      end

      StGap: begin
        nState = StIdle;
      end

      default: begin
        nState = StIdle;
      end
    endcase
  end

  always_ff @(posedge PHI2) begin
    if (!nRESET) begin
      state   <= StIdle;
      pfValid <= 1'b0;
      pfAddr  <= '0;
      pfData  <= '0;
      MemREQ  <= 1'b0;
      MemADDR <= '0;
      stale   <= 1'b0;
    end else begin
      state   <= nState;
      pfValid <= nPfValid;
      pfAddr  <= nPfAddr;
      pfData  <= nPfData;
      MemREQ  <= nMemReq;
      MemADDR <= nMemAddr;
      stale   <= nStale;
    end
  end

endmodule

// File: tb/tb_geo_window_rd.sv
// tb/tb_geo_window_rd.sv - self-checking bench for geo_window_rd
// Directed scenarios plus a randomized run checked against a shadow backing-RAM model.
module tb_geo_window_rd;

  logic        PHI2 = 1'b0;
  logic        nRESET = 1'b0;
  logic        WinSEL = 1'b0;
  logic        nWE = 1'b1;
  logic [7:0]  A = 8'h00;
  logic [7:0]  WRD = 8'h00;
  logic [7:0]  Block = 8'h00;
  logic [5:0]  Window = 6'h00;
  logic [7:0]  RDD;
  logic        RDOE;
  logic        Stall;
  logic        MemREQ;
  logic [21:0] MemADDR;
  logic        MemACK = 1'b0;
  logic [7:0]  MemRD = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  logic       autoAck = 1'b0;
  int         ackLat = 0;
  int         gapLeft = 0;
  logic [7:0] ramW [int];

  geo_window_rd #(.MEM_AW(22), .NOFETCH(1'b0)) dut (
    .PHI2(PHI2), .nRESET(nRESET), .WinSEL(WinSEL), .nWE(nWE), .A(A), .WRD(WRD),
    .Block(Block), .Window(Window), .RDD(RDD), .RDOE(RDOE), .Stall(Stall),
    .MemREQ(MemREQ), .MemADDR(MemADDR), .MemACK(MemACK), .MemRD(MemRD)
  );

  always #5 PHI2 = ~PHI2;

  // Backing RAM contents: a fixed pattern overlaid with everything the C64 wrote.
  function automatic logic [7:0] ramRd(input logic [21:0] a);
    if (ramW.exists(int'(a))) return ramW[int'(a)];
    return a[7:0] ^ {a[13:8], 2'b01} ^ a[21:14];
  endfunction

  task automatic tick();
    @(posedge PHI2);
    #1;
  endtask

  task automatic doReset();
    nRESET = 1'b0; WinSEL = 1'b0; nWE = 1'b1; MemACK = 1'b0;
    tick(); tick();
    nRESET = 1'b1;
  endtask

  task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
    WinSEL = 1'b1; nWE = 1'b1; A = a;
    tick();
    MemACK = 1'b1; MemRD = d;
    tick();
    MemACK = 1'b0; WinSEL = 1'b0;
    tick();
  endtask

  task automatic respond();
    if (MemACK) begin
      MemACK = 1'b0;
    end else if (MemREQ) begin
      if (ackLat == 0) begin
        MemACK = 1'b1;
        MemRD  = ramRd(MemADDR);
        ackLat = $urandom_range(0, 3);
      end else begin
        ackLat--;
      end
    end
  endtask

  task automatic stepRand();
    logic pReq, pAck;
    logic [21:0] pAddr;
    pReq = MemREQ; pAck = MemACK; pAddr = MemADDR;
    tick();
    if (pAck) gapLeft = 2;
    if (gapLeft > 0) begin
      vectors++;
      if (MemREQ !== 1'b0) begin
        miscompares++; $display("FAIL rand_gap: MemREQ=%b required 0", MemREQ);
      end
      gapLeft--;
    end else if (pReq) begin
      vectors++;
      if (MemREQ !== 1'b1 || MemADDR !== pAddr) begin
        miscompares++;
        $display("FAIL rand_hold: MemREQ=%b MemADDR=%h required 1 %h", MemREQ, MemADDR, pAddr);
      end
    end
    respond();
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if (MemREQ !== 1'b0 || MemADDR !== 22'h0 || RDOE !== 1'b0 || Stall !== 1'b0 || RDD !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: REQ=%b ADDR=%h RDOE=%b Stall=%b RDD=%h required 0 0 0 0 0",
               MemREQ, MemADDR, RDOE, Stall, RDD);
    end
    Block = 8'h00; Window = 6'h00; A = 8'h00; WinSEL = 1'b1; nWE = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0) begin
      miscompares++; $display("FAIL reset_addr0_miss: Stall=%b RDOE=%b required 1 0", Stall, RDOE);
    end
    WinSEL = 1'b0;
  endtask

  task automatic test_miss_fetch();
    doReset();
    Block = 8'h12; Window = 6'h05; A = 8'h40; WinSEL = 1'b1; nWE = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0) begin
      miscompares++; $display("FAIL miss_stall: Stall=%b RDOE=%b required 1 0", Stall, RDOE);
    end
    tick();
    vectors++;
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048540) begin
      miscompares++; $display("FAIL miss_req: REQ=%b ADDR=%h required 1 048540", MemREQ, MemADDR);
    end
    tick(); tick();
    vectors++;
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048540 || Stall !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_hold: REQ=%b ADDR=%h Stall=%b required 1 048540 1", MemREQ, MemADDR, Stall);
    end
    MemACK = 1'b1; MemRD = 8'h5A;
    tick();
    MemACK = 1'b0;
    vectors++;
    if (MemREQ !== 1'b0 || RDOE !== 1'b1 || RDD !== 8'h5A || Stall !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_ack: REQ=%b RDOE=%b RDD=%h Stall=%b required 0 1 5a 0", MemREQ, RDOE, RDD, Stall);
    end
    tick();
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'h5A || MemREQ !== 1'b0) begin
      miscompares++; $display("FAIL miss_after_gap: RDOE=%b RDD=%h REQ=%b required 1 5a 0", RDOE, RDD, MemREQ);
    end
    tick();
    vectors++;
`ifdef GEO_RD_PREFETCH_EN
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048541) begin
      miscompares++; $display("FAIL hit_prefetch: REQ=%b ADDR=%h required 1 048541", MemREQ, MemADDR);
    end
`else
    if (MemREQ !== 1'b0) begin
      miscompares++; $display("FAIL hit_no_fetch: REQ=%b required 0", MemREQ);
    end
`endif
    WinSEL = 1'b0;
  endtask

  task automatic test_prefetch_wrap();
    doReset();
    Block = 8'h12; Window = 6'h05;
    loadByte(8'hFF, 8'h3C);
    WinSEL = 1'b1; nWE = 1'b1; A = 8'hFF;
    #1;
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'h3C) begin
      miscompares++; $display("FAIL wrap_hit: RDOE=%b RDD=%h required 1 3c", RDOE, RDD);
    end
    tick();
    vectors++;
`ifdef GEO_RD_PREFETCH_EN
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048500) begin
      miscompares++; $display("FAIL wrap_addr: REQ=%b ADDR=%h required 1 048500", MemREQ, MemADDR);
    end
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'h3C) begin
      miscompares++; $display("FAIL wrap_old_hit: RDOE=%b RDD=%h required 1 3c", RDOE, RDD);
    end
    MemACK = 1'b1; MemRD = 8'hC3;
    tick();
    MemACK = 1'b0; A = 8'h00;
    #1;
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'hC3) begin
      miscompares++; $display("FAIL wrap_next_hit: RDOE=%b RDD=%h required 1 c3", RDOE, RDD);
    end
`else
    if (MemREQ !== 1'b0) begin
      miscompares++; $display("FAIL wrap_no_req: REQ=%b required 0", MemREQ);
    end
    A = 8'h00;
    #1;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0) begin
      miscompares++; $display("FAIL wrap_next_miss: Stall=%b RDOE=%b required 1 0", Stall, RDOE);
    end
`endif
    WinSEL = 1'b0;
  endtask

  task automatic test_write_snoop();
    doReset();
    Block = 8'h12; Window = 6'h05;
    loadByte(8'h40, 8'h5A);
    WinSEL = 1'b1; nWE = 1'b0; A = 8'h40; WRD = 8'h77;
    #1;
    vectors++;
    if (RDOE !== 1'b0 || Stall !== 1'b0) begin
      miscompares++; $display("FAIL snoop_wr_cycle: RDOE=%b Stall=%b required 0 0", RDOE, Stall);
    end
    tick();
    nWE = 1'b1;
    #1;
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'h77) begin
      miscompares++; $display("FAIL snoop_data: RDOE=%b RDD=%h required 1 77", RDOE, RDD);
    end
    tick();
    vectors++;
`ifdef GEO_RD_PREFETCH_EN
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048541) begin
      miscompares++; $display("FAIL snoop_req: REQ=%b ADDR=%h required 1 048541", MemREQ, MemADDR);
    end
`else
    if (MemREQ !== 1'b0) begin
      miscompares++; $display("FAIL snoop_req: REQ=%b required 0", MemREQ);
    end
`endif
    WinSEL = 1'b0;
  endtask

  task automatic test_stale_write();
    doReset();
    Block = 8'h12; Window = 6'h05; A = 8'h40; WinSEL = 1'b1; nWE = 1'b1;
    tick();
    nWE = 1'b0; WRD = 8'h99;
    tick();
    nWE = 1'b1; MemACK = 1'b1; MemRD = 8'h11;
    tick();
    MemACK = 1'b0;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0 || MemREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_discard: Stall=%b RDOE=%b REQ=%b required 1 0 0", Stall, RDOE, MemREQ);
    end
    tick();
    vectors++;
    if (Stall !== 1'b1 || MemREQ !== 1'b0) begin
      miscompares++; $display("FAIL stale_gap: Stall=%b REQ=%b required 1 0", Stall, MemREQ);
    end
    tick();
    vectors++;
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048540) begin
      miscompares++; $display("FAIL stale_refetch: REQ=%b ADDR=%h required 1 048540", MemREQ, MemADDR);
    end
    MemACK = 1'b1; MemRD = 8'h99;
    tick();
    MemACK = 1'b0;
    vectors++;
    if (RDOE !== 1'b1 || RDD !== 8'h99) begin
      miscompares++; $display("FAIL stale_final: RDOE=%b RDD=%h required 1 99", RDOE, RDD);
    end
    WinSEL = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    doReset();
    Block = 8'h12; Window = 6'h05; A = 8'h40; WinSEL = 1'b1; nWE = 1'b1;
    tick();
    vectors++;
    if (MemREQ !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_req: REQ=%b required 1", MemREQ);
    end
    nRESET = 1'b0;
    tick();
    vectors++;
    if (MemREQ !== 1'b0 || MemADDR !== 22'h0) begin
      miscompares++; $display("FAIL rst_mid_clear: REQ=%b ADDR=%h required 0 0", MemREQ, MemADDR);
    end
    nRESET = 1'b1; WinSEL = 1'b0; MemACK = 1'b1; MemRD = 8'hAB;
    tick();
    MemACK = 1'b0; WinSEL = 1'b1; nWE = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0 || MemREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_late_ack: Stall=%b RDOE=%b REQ=%b required 1 0 0", Stall, RDOE, MemREQ);
    end
    tick();
    vectors++;
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048540) begin
      miscompares++; $display("FAIL rst_refetch: REQ=%b ADDR=%h required 1 048540", MemREQ, MemADDR);
    end
    WinSEL = 1'b0;
  endtask

  task automatic test_window_change();
    doReset();
    Block = 8'h12; Window = 6'h05;
    loadByte(8'h40, 8'h5A);
    Window = 6'h06; A = 8'h40; WinSEL = 1'b1; nWE = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b1 || RDOE !== 1'b0) begin
      miscompares++; $display("FAIL win_miss: Stall=%b RDOE=%b required 1 0", Stall, RDOE);
    end
    tick();
    vectors++;
    if (MemREQ !== 1'b1 || MemADDR !== 22'h048640) begin
      miscompares++; $display("FAIL win_addr: REQ=%b ADDR=%h required 1 048640", MemREQ, MemADDR);
    end
    WinSEL = 1'b0;
  endtask

  task automatic test_random();
    logic [21:0] cur;
    logic done;
    int op;
    doReset();
    autoAck = 1'b1; ackLat = 0; gapLeft = 0; MemACK = 1'b0;
    for (int t = 0; t < 300; t++) begin
      Block  = ($urandom_range(0, 3) == 0) ? 8'h13 : 8'h12;
      Window = ($urandom_range(0, 3) == 0) ? 6'h06 : 6'h05;
      if ($urandom_range(0, 1) == 1) A = A + 8'd1;
      else A = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      cur = {Block, Window, A};
      op = $urandom_range(0, 9);
      if (op < 6) begin
        WinSEL = 1'b1; nWE = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
          #1;
          vectors++;
          if (RDOE === Stall) begin
            miscompares++; $display("FAIL rand_excl: RDOE=%b Stall=%b required opposite", RDOE, Stall);
          end
          if (RDOE === 1'b1) begin
            done = 1'b1;
            vectors++;
            if (RDD !== ramRd(cur)) begin
              miscompares++; $display("FAIL rand_data @%h: RDD=%h required %h", cur, RDD, ramRd(cur));
            end
          end
          stepRand();
        end
        if (!done) begin
          miscompares++; $display("FAIL rand_timeout @%h: no RDOE within 40 cycles", cur);
        end
      end else begin
        WinSEL = (op < 8); nWE = 1'b0; WRD = 8'($urandom_range(0, 255));
        if (op < 8) ramW[int'(cur)] = WRD;
        #1;
        vectors++;
        if (RDOE !== 1'b0 || Stall !== 1'b0) begin
          miscompares++; $display("FAIL rand_nonread: RDOE=%b Stall=%b required 0 0", RDOE, Stall);
        end
        stepRand();
      end
    end
    WinSEL = 1'b0; nWE = 1'b1;
    autoAck = 1'b0; MemACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fetch();
    test_prefetch_wrap();
    test_write_snoop();
    test_stale_write();
    test_reset_mid_fetch();
    test_window_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
